evenodd_stream_driver: RTL and testbench

Transmit-side counterpart of the even/odd classifier. Buffers host-supplied bytes in a small FIFO and streams them one per cycle on the classifier's `in_valid`/`data_in` interface. Captures the classifier's `even`/`odd` response, checks it against each byte's LSB, and keeps saturating pass/fail counts. It sits beside the classifier as its on-chip stimulus source and self-checker.

---
 rtl/evenodd_stream_driver_if.sv | 29 ++
 rtl/evenodd_stream_driver.sv | 111 +++++++++++
 tb/tb_evenodd_stream_driver.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/evenodd_stream_driver_if.sv
// Host and classifier-facing signals of the even/odd stream driver.
// The slave view belongs to the driver; the master view belongs to whatever surrounds it.
interface evenodd_stream_driver_if #(
  parameter int CNT_W = 8
);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             start;
  logic             pause;
  logic             out_valid;
  logic [7:0]       data_out;
  logic             even_in;
  logic             odd_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output wr_en, wr_data, start, pause, even_in, odd_in,
    input  full, out_valid, data_out, busy, done, pass_cnt, fail_cnt
  );

  modport slave (
    input  wr_en, wr_data, start, pause, even_in, odd_in,
    output full, out_valid, data_out, busy, done, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/evenodd_stream_driver.sv
// Streams FIFO-buffered bytes into an even/odd classifier and scores its replies
// with saturating pass/fail counters.
module evenodd_stream_driver #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  evenodd_stream_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      cnt_q;
  logic             empty, full, push, pop, clr_cnt, busy, done;
  logic [1:0]       vld_pipe_q;
  logic [7:0]       data_q;
  logic             lsb_q;
  logic [CNT_W-1:0] pass_q, fail_q;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = bus.wr_en & ~full;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A pending write keeps the burst alive so a just-arrived byte still goes out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (empty && !bus.wr_en && !bus.pause) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    clr_cnt = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:    clr_cnt = bus.start;
      RUN:     pop     = ~empty & ~bus.pause;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // vld_pipe_q[0] is the presented byte, [1] the one whose reply is due this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      data_q     <= '0;
      lsb_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], pop};
      if (pop) data_q <= mem_q[rd_ptr_q];
      lsb_q      <= data_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      pass_q <= '0;
      fail_q <= '0;
    end else if (vld_pipe_q[1]) begin
      if (bus.odd_in == lsb_q && bus.even_in == ~lsb_q) begin
        if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
      end else begin
        if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
      end
    end
  end

  assign bus.full      = full;
  assign bus.out_valid = vld_pipe_q[0];
  assign bus.data_out  = data_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass_cnt  = pass_q;
  assign bus.fail_cnt  = fail_q;
endmodule

// File: tb/tb_evenodd_stream_driver.sv
// Bench for evenodd_stream_driver: registered classifier model, byte scoreboard,
// table of bursts plus hand sequences for overflow, empty start, abort and saturation.
module tb_evenodd_stream_driver;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  evenodd_stream_driver_if #(.CNT_W(CNT_W)) ifc();

  evenodd_stream_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  bit         force0 = 1'b0;

  // Classifier: registers its answer when in_valid, holds otherwise.
  always @(posedge clk) begin
    if (reset) begin
      ifc.even_in <= 1'b0;
      ifc.odd_in  <= 1'b0;
    end else if (ifc.out_valid) begin
      ifc.even_in <= force0 ? 1'b0 : ~ifc.data_out[0];
      ifc.odd_in  <= force0 ? 1'b0 :  ifc.data_out[0];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ifc.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra actual=%0d expected=none", ifc.data_out);
      end else begin
        chk("data_out", int'(ifc.data_out), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_full"},      int'(ifc.full),      0);
    chk({tag, "_out_valid"}, int'(ifc.out_valid), 0);
    chk({tag, "_data_out"},  int'(ifc.data_out),  0);
    chk({tag, "_busy"},      int'(ifc.busy),      0);
    chk({tag, "_done"},      int'(ifc.done),      0);
    chk({tag, "_pass"},      int'(ifc.pass_cnt),  0);
    chk({tag, "_fail"},      int'(ifc.fail_cnt),  0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    ifc.wr_en = 1'b0; ifc.wr_data = 8'h00; ifc.start = 1'b0; ifc.pause = 1'b0;
    tick;
    check_zero(tag);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    ifc.wr_en = 1'b1;
    ifc.wr_data = b;
    if (accept) exp_q.push_back(b);
    tick;
    ifc.wr_en = 1'b0;
  endtask

  task automatic start_burst;
    ifc.start = 1'b1;
    tick;
    ifc.start = 1'b0;
  endtask

  // Counts edges after E0 until done; pause/start are driven for the next edge.
  task automatic run_burst(input int pa, input int pl, input bit ms,
                           output int done_k, output int nv);
    done_k = -1;
    nv = 0;
    for (int k = 1; k <= 400; k++) begin
      tick;
      if (ifc.out_valid) nv++;
      if (ifc.done) begin
        done_k = k;
        break;
      end
      ifc.pause = (pl > 0 && k >= pa && k < pa + pl);
      if (ms) ifc.start = (k == 1);
    end
    ifc.pause = 1'b0;
    ifc.start = 1'b0;
    if (done_k < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none expected=pulse");
    end
  endtask

  task automatic finish_burst(input string tag, input int ep, input int ef);
    chk({tag, "_pass"}, int'(ifc.pass_cnt), ep);
    chk({tag, "_fail"}, int'(ifc.fail_cnt), ef);
    tick;
    chk({tag, "_done_pulse"}, int'(ifc.done), 0);
    chk({tag, "_busy_end"},   int'(ifc.busy), 0);
    chk({tag, "_sb_empty"},   exp_q.size(),   0);
  endtask

  typedef struct {
    int          n;
    logic [31:0] b;   // byte i at b[8*i +: 8]
    bit          f0;
    int          pa;
    int          pl;
    int          ep;
    int          ef;
    int          ed;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int dk, nv, dn;
    ifc.wr_en = 1'b0; ifc.wr_data = 8'h00; ifc.start = 1'b0; ifc.pause = 1'b0;

    vecs[0] = '{4, 32'hFF02_0100, 1'b0, 0, 0, 4, 0, 6};
    vecs[1] = '{4, 32'h04FE_7F80, 1'b0, 2, 2, 4, 0, 8};
    vecs[2] = '{3, 32'h000C_0B0A, 1'b1, 0, 0, 0, 3, 5};
    vecs[3] = '{1, 32'h0000_0007, 1'b0, 0, 0, 1, 0, 3};

    for (int v = 0; v < 4; v++) begin
      do_reset($sformatf("v%0d_rst", v));
      force0 = vecs[v].f0;
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].b[8*i +: 8], 1'b1);
      start_burst;
      chk($sformatf("v%0d_busy", v), int'(ifc.busy), 1);
      run_burst(vecs[v].pa, vecs[v].pl, 1'b0, dk, nv);
      chk($sformatf("v%0d_done_edge", v), dk, vecs[v].ed);
      chk($sformatf("v%0d_nvalid", v), nv, vecs[v].n);
      finish_burst($sformatf("v%0d", v), vecs[v].ep, vecs[v].ef);
    end
    force0 = 1'b0;

    // Overflow: DEPTH+1 pushes, last one dropped.
    do_reset("ovf_rst");
    for (int i = 0; i <= DEPTH; i++) begin
      push(8'(8'h30 + i), i < DEPTH);
      if (i == DEPTH - 2) chk("ovf_not_full", int'(ifc.full), 0);
      if (i >= DEPTH - 1) chk("ovf_full", int'(ifc.full), 1);
    end
    start_burst;
    run_burst(0, 0, 1'b0, dk, nv);
    chk("ovf_nvalid", nv, DEPTH);
    chk("ovf_done_edge", dk, DEPTH + 2);
    finish_burst("ovf", DEPTH, 0);

    // Empty start: DRAIN at E1, done after E2.
    do_reset("empty_rst");
    start_burst;
    chk("empty_busy", int'(ifc.busy), 1);
    run_burst(0, 0, 1'b0, dk, nv);
    chk("empty_done_edge", dk, 2);
    chk("empty_nvalid", nv, 0);
    finish_burst("empty", 0, 0);

    // start pulsed mid-burst must not restart or extend it.
    do_reset("mid_rst");
    for (int i = 0; i < 3; i++) push(8'(8'h41 + i), 1'b1);
    start_burst;
    run_burst(0, 0, 1'b1, dk, nv);
    chk("mid_done_edge", dk, 5);
    finish_burst("mid", 3, 0);
    tick;
    chk("mid_stays_idle", int'(ifc.busy), 0);

    // Reset after 2 of 5 bytes: abort, no done, FIFO discarded.
    do_reset("abort_rst");
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i), 1'b1);
    start_burst;
    tick;
    tick;
    reset = 1'b1;
    tick;
    check_zero("abort");
    reset = 1'b0;
    exp_q.delete();
    dn = 0;
    repeat (4) begin
      tick;
      dn += int'(ifc.done);
    end
    chk("abort_no_done", dn, 0);
    push(8'h55, 1'b1);
    push(8'hAA, 1'b1);
    start_burst;
    run_burst(0, 0, 1'b0, dk, nv);
    chk("abort_nvalid", nv, 2);
    chk("abort_done_edge", dk, 4);
    finish_burst("abort", 2, 0);

    // Writes during RUN keep the burst going; 260 replies saturate a counter.
    for (int f = 0; f < 2; f++) begin
      do_reset($sformatf("sat%0d_rst", f));
      force0 = (f == 1);
      push(8'h00, 1'b1);
      start_burst;
      ifc.wr_en = 1'b1;
      for (int i = 1; i < 260; i++) begin
        ifc.wr_data = 8'(i);
        exp_q.push_back(8'(i));
        tick;
      end
      ifc.wr_en = 1'b0;
      run_burst(0, 0, 1'b0, dk, nv);
      finish_burst($sformatf("sat%0d", f), f ? 0 : 255, f ? 255 : 0);
    end
    force0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
